// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//
// Execute-entry stage that sits directly in front of the combinational ALU.
// It accepts one RV32I instruction per valid/ready handshake, together with
// its pc and register-file read values. OP, OP-IMM, LUI and AUIPC are decoded
// into ALU operands a/b and an AluFunc code. The results are presented
// registered through a 2-entry skid buffer (head + skid), in strict FIFO
// order. Any other encoding passes through as a NOP with rd_we=0.
//
// Optional feature (compile-time macro ALU_OPERAND_ILLEGAL_EN):
//   Adds output illegal_out, which is stored per entry and flags unsupported
//   or malformed encodings. Without the macro those encodings still become
//   NOPs, but nothing flags them.
//
// Ports
//   clk_in      in   1      rising-edge clock
//   rst_in      in   1      asynchronous active-high reset
//   flush_in    in   1      synchronous discard of all buffered entries
//   in_valid    in   1      upstream offers an instruction
//   in_ready    out  1      stage can accept (registered, = !skid valid)
//   inst_in     in   32     raw instruction word
//   pc_in       in   XLEN   instruction address
//   rs1_in      in   XLEN   x[rs1]
//   rs2_in      in   XLEN   x[rs2]
//   out_valid   out  1      head entry valid
//   out_ready   in   1      downstream consumes head entry
//   a_out       out  XLEN   ALU operand a
//   b_out       out  XLEN   ALU operand b
//   func_out    out  4      ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLTU6 SLL7 SRL8 SRA9
//   rd_out      out  5      destination register
//   rd_we_out   out  1      rd write enable
//   illegal_out out  1      (ALU_OPERAND_ILLEGAL_EN only) illegal encoding
// ---------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            flush_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a_out,
  output logic [XLEN-1:0] b_out,
  output logic [3:0]      func_out,
  output logic [4:0]      rd_out,
  output logic            rd_we_out
`ifdef ALU_OPERAND_ILLEGAL_EN
  ,
  output logic            illegal_out
`endif
);

  typedef enum logic [3:0] {
    FN_ADD  = 4'd0,
    FN_SUB  = 4'd1,
    FN_AND  = 4'd2,
    FN_OR   = 4'd3,
    FN_XOR  = 4'd4,
    FN_SLT  = 4'd5,
    FN_SLTU = 4'd6,
    FN_SLL  = 4'd7,
    FN_SRL  = 4'd8,
    FN_SRA  = 4'd9
  } alu_func_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_func_e       func;
    logic [4:0]      rd;
    logic            rd_we;
`ifdef ALU_OPERAND_ILLEGAL_EN
    logic            illegal;
`endif
  } entry_t;

  // The ALU shifts by the full b operand, so shift amounts are zero-extended
  // from 5 bits here rather than passed through unmasked.
  function automatic logic [XLEN-1:0] shamt_ext(input logic [4:0] s);
    return {{(XLEN-5){1'b0}}, s};
  endfunction

  // ---- stage p0: combinational decode of the incoming instruction ----
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic            unused_rs1_field;

  assign opcode = inst_in[6:0];
  assign funct3 = inst_in[14:12];
  assign funct7 = inst_in[31:25];
  assign imm_i  = {{(XLEN-12){inst_in[31]}}, inst_in[31:20]};
  assign imm_u  = {{(XLEN-32){inst_in[31]}}, inst_in[31:12], 12'b0};
  // The rs1 index is resolved upstream; only its value arrives here.
  assign unused_rs1_field = ^inst_in[19:15];

  entry_t dec_p0;
  logic   legal_p0;

  always_comb begin
    dec_p0      = '0;
    dec_p0.func = FN_ADD;
    dec_p0.rd   = inst_in[11:7];
    legal_p0    = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec_p0.a = rs1_in;
        dec_p0.b = rs2_in;
        case (funct3)
          3'b000: dec_p0.func = funct7[5] ? FN_SUB : FN_ADD;
          3'b001: begin
            dec_p0.func = FN_SLL;
            dec_p0.b    = shamt_ext(rs2_in[4:0]);
          end
          3'b010: dec_p0.func = FN_SLT;
          3'b011: dec_p0.func = FN_SLTU;
          3'b100: dec_p0.func = FN_XOR;
          3'b101: begin
            dec_p0.func = funct7[5] ? FN_SRA : FN_SRL;
            dec_p0.b    = shamt_ext(rs2_in[4:0]);
          end
          3'b110: dec_p0.func = FN_OR;
          default: dec_p0.func = FN_AND;
        endcase
        // funct7 alternate form exists only for SUB and SRA.
        if (funct7 != F7_BASE &&
            !(funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
          legal_p0 = 1'b0;
      end
      OPC_OPIMM: begin
        dec_p0.a = rs1_in;
        dec_p0.b = imm_i;
        case (funct3)
          3'b000: dec_p0.func = FN_ADD;
          3'b001: begin
            dec_p0.func = FN_SLL;
            dec_p0.b    = shamt_ext(inst_in[24:20]);
            legal_p0    = (funct7 == F7_BASE);
          end
          3'b010: dec_p0.func = FN_SLT;
          3'b011: dec_p0.func = FN_SLTU;
          3'b100: dec_p0.func = FN_XOR;
          3'b101: begin
            dec_p0.func = funct7[5] ? FN_SRA : FN_SRL;
            dec_p0.b    = shamt_ext(inst_in[24:20]);
            legal_p0    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          3'b110: dec_p0.func = FN_OR;
          default: dec_p0.func = FN_AND;
        endcase
      end
      OPC_LUI: begin
        dec_p0.a = '0;
        dec_p0.b = imm_u;
      end
      OPC_AUIPC: begin
        dec_p0.a = pc_in;
        dec_p0.b = imm_u;
      end
      default: legal_p0 = 1'b0;
    endcase
    // Anything not decodable collapses to a harmless NOP.
    if (!legal_p0) begin
      dec_p0.a    = '0;
      dec_p0.b    = '0;
      dec_p0.func = FN_ADD;
    end
    dec_p0.rd_we = legal_p0 && (inst_in[11:7] != 5'd0);
`ifdef ALU_OPERAND_ILLEGAL_EN
    dec_p0.illegal = !legal_p0;
`endif
  end

  // ---- stage p1: head / skid storage ----
  entry_t head_p1;
  entry_t skid_p1;
  logic   vld_head_p1;
  logic   vld_skid_p1;
  logic   in_fire;
  logic   out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = vld_head_p1 && out_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_p1     <= '0;
      skid_p1     <= '0;
      vld_head_p1 <= 1'b0;
      vld_skid_p1 <= 1'b0;
    end else if (flush_in) begin
      vld_head_p1 <= 1'b0;
      vld_skid_p1 <= 1'b0;
    end else if (out_fire) begin
      // Skid full implies in_ready=0, so no new entry can arrive alongside it.
      if (vld_skid_p1) begin
        head_p1     <= skid_p1;
        vld_skid_p1 <= 1'b0;
      end else if (in_fire) begin
        head_p1 <= dec_p0;
      end else begin
        vld_head_p1 <= 1'b0;
      end
    end else if (in_fire) begin
      if (!vld_head_p1) begin
        head_p1     <= dec_p0;
        vld_head_p1 <= 1'b1;
      end else begin
        skid_p1     <= dec_p0;
        vld_skid_p1 <= 1'b1;
      end
    end
  end

  assign in_ready  = !vld_skid_p1;
  assign out_valid = vld_head_p1;
  assign a_out     = head_p1.a;
  assign b_out     = head_p1.b;
  assign func_out  = head_p1.func;
  assign rd_out    = head_p1.rd;
  assign rd_we_out = head_p1.rd_we;
`ifdef ALU_OPERAND_ILLEGAL_EN
  assign illegal_out = head_p1.illegal;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst_in;
  logic [31:0] pc_in;
  logic [31:0] rs1_in;
  logic [31:0] rs2_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [3:0]  func_out;
  logic [4:0]  rd_out;
  logic        rd_we_out;
`ifdef ALU_OPERAND_ILLEGAL_EN
  logic        illegal_out;
`endif

  int vectors    = 0;
  int miscompares = 0;

  alu_operand_stage #(.XLEN(32)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush_in  (flush_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst_in   (inst_in),
    .pc_in     (pc_in),
    .rs1_in    (rs1_in),
    .rs2_in    (rs2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .func_out  (func_out),
    .rd_out    (rd_out),
    .rd_we_out (rd_we_out)
`ifdef ALU_OPERAND_ILLEGAL_EN
    ,
    .illegal_out (illegal_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Present one instruction for exactly one edge.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    inst_in  = inst;
    pc_in    = pc;
    rs1_in   = r1;
    rs2_in   = r2;
    cyc();
    in_valid = 1'b0;
  endtask

  logic signed [31:0] sra_a;
  logic        [31:0] sra_res;

  initial begin
    rst_in    = 1'b1;
    flush_in  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inst_in   = '0;
    pc_in     = '0;
    rs1_in    = '0;
    rs2_in    = '0;
    repeat (2) cyc();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_a",         a_out,              32'd0);
    chk("rst_b",         b_out,              32'd0);
    chk("rst_func",      {28'b0, func_out},  32'd0);
    chk("rst_rd",        {27'b0, rd_out},    32'd0);
    chk("rst_rd_we",     {31'b0, rd_we_out}, 32'd0);
    rst_in = 1'b0;
    cyc();

    // add x3,x1,x2
    out_ready = 1'b1;
    send(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_a",     a_out,              32'd5);
    chk("add_b",     b_out,              32'd7);
    chk("add_func",  {28'b0, func_out},  32'd0);
    chk("add_rd",    {27'b0, rd_out},    32'd3);
    chk("add_rd_we", {31'b0, rd_we_out}, 32'd1);
    cyc();
    chk("add_drained", {31'b0, out_valid}, 32'd0);

    // srai x3,x1,3
    send(32'h4030D193, 32'h0, 32'h80000000, 32'h0);
    chk("srai_a",    a_out,             32'h80000000);
    chk("srai_b",    b_out,             32'd3);
    chk("srai_func", {28'b0, func_out}, 32'd9);
    sra_a   = a_out;
    sra_res = sra_a >>> b_out[4:0];
    chk("srai_res",  sra_res,           32'hF0000000);

    // sub x4,x1,x2 back-to-back: replaces head with no bubble
    send(32'h40208233, 32'h0, 32'd5, 32'd7);
    chk("sub_valid", {31'b0, out_valid}, 32'd1);
    chk("sub_func",  {28'b0, func_out},  32'd1);
    chk("sub_rd",    {27'b0, rd_out},    32'd4);

    // sll x5,x1,x2 with rs2=0x25: shift operand masked to 5
    send(32'h002092B3, 32'h0, 32'd1, 32'h00000025);
    chk("sll_b",    b_out,             32'd5);
    chk("sll_func", {28'b0, func_out}, 32'd7);

    // addi x0,x1,-1: sign-extended imm, rd==0 suppresses write
    send(32'hFFF08013, 32'h0, 32'd9, 32'h0);
    chk("addi_b",     b_out,              32'hFFFFFFFF);
    chk("addi_rd_we", {31'b0, rd_we_out}, 32'd0);

    // auipc x5,0x12345 at pc 0x100
    send(32'h12345297, 32'h100, 32'h0, 32'h0);
    chk("auipc_a",     a_out,              32'h100);
    chk("auipc_b",     b_out,              32'h12345000);
    chk("auipc_func",  {28'b0, func_out},  32'd0);
    chk("auipc_rd",    {27'b0, rd_out},    32'd5);
    chk("auipc_rd_we", {31'b0, rd_we_out}, 32'd1);

    // lui x6,0xABCDE
    send(32'hABCDE337, 32'h0, 32'h55555555, 32'h0);
    chk("lui_a", a_out, 32'd0);
    chk("lui_b", b_out, 32'hABCDE000);

    // fence: not an ALU op
    send(32'h0000000F, 32'h0, 32'h11, 32'h22);
    chk("fence_valid", {31'b0, out_valid}, 32'd1);
    chk("fence_rd_we", {31'b0, rd_we_out}, 32'd0);
    chk("fence_b",     b_out,              32'd0);
`ifdef ALU_OPERAND_ILLEGAL_EN
    chk("fence_illegal", {31'b0, illegal_out}, 32'd1);
`endif

    // OP with funct7=0000001 (mul): NOP
    send(32'h022081B3, 32'h0, 32'd5, 32'd7);
    chk("mul_rd_we", {31'b0, rd_we_out}, 32'd0);
    chk("mul_a",     a_out,              32'd0);
`ifdef ALU_OPERAND_ILLEGAL_EN
    chk("mul_illegal", {31'b0, illegal_out}, 32'd1);
`endif
    cyc();
    chk("pre_stall_empty", {31'b0, out_valid}, 32'd0);

    // Stall: three back-to-back offers with out_ready=0
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rs1_in    = 32'h0;
    inst_in   = 32'h00100093;  // addi x1,x0,1
    cyc();
    chk("stall1_in_ready", {31'b0, in_ready},  32'd1);
    chk("stall1_valid",    {31'b0, out_valid}, 32'd1);
    chk("stall1_b",        b_out,              32'd1);
    inst_in = 32'h00200113;    // addi x2,x0,2
    cyc();
    chk("stall2_in_ready", {31'b0, in_ready}, 32'd0);
    chk("stall2_b",        b_out,             32'd1);
    inst_in = 32'h00300193;    // addi x3,x0,3 (must not be taken yet)
    cyc();
    chk("stall3_in_ready", {31'b0, in_ready}, 32'd0);
    chk("stall3_b",        b_out,             32'd1);
    chk("stall3_rd",       {27'b0, rd_out},   32'd1);
    cyc();
    chk("stall4_b", b_out, 32'd1);
    out_ready = 1'b1;
    cyc();
    chk("drain1_b",        b_out,              32'd2);
    chk("drain1_rd",       {27'b0, rd_out},    32'd2);
    chk("drain1_in_ready", {31'b0, in_ready},  32'd1);
    cyc();
    chk("drain2_b",        b_out,              32'd3);
    chk("drain2_rd",       {27'b0, rd_out},    32'd3);
    in_valid = 1'b0;
    cyc();
    chk("drain3_empty", {31'b0, out_valid}, 32'd0);

    // Flush with two entries held; concurrent offer is dropped
    out_ready = 1'b0;
    send(32'h00100093, 32'h0, 32'h0, 32'h0);
    send(32'h00200113, 32'h0, 32'h0, 32'h0);
    chk("preflush_in_ready", {31'b0, in_ready}, 32'd0);
    flush_in = 1'b1;
    in_valid = 1'b1;
    inst_in  = 32'h00300193;
    cyc();
    flush_in = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid",    {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready},  32'd1);
    cyc();
    chk("flush_dropped", {31'b0, out_valid}, 32'd0);

    // Async reset mid-cycle with two entries held
    send(32'h00500093, 32'h0, 32'h0, 32'h0);
    send(32'h00600113, 32'h0, 32'h0, 32'h0);
    chk("prerst_b", b_out, 32'd5);
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_valid",    {31'b0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready},  32'd1);
    chk("arst_b",        b_out,              32'd0);
    chk("arst_rd",       {27'b0, rd_out},    32'd0);
    chk("arst_rd_we",    {31'b0, rd_we_out}, 32'd0);
    cyc();
    rst_in = 1'b0;
    cyc();
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
